updown_sweep_ctrl: RTL and testbench
====================================

// Module: updown_sweep_ctrl
// PURPOSE
//   Sequences an up/down counter through programmed triangle sweeps between lo and hi bounds.
//   Owns the counter register and its direction, with a start/busy/done handshake, hold and abort.
//   Drives sweep-address/level generators downstream; software-style config is sampled on start.
// PARAMETERS
//   WIDTH   4  counter and bound width (bits)
//   NCYC_W  4  width of sweep-count field
// PORTS
//   clk       in   1        rising-edge clock
//   rst       in   1        reset, synchronous, active-high
//   start     in   1        begin sequence; honoured only in IDLE
//   lo        in   WIDTH    lower bound, sampled on accepted start
//   hi        in   WIDTH    upper bound, sampled on accepted start
//   n_cycles  in   NCYC_W   number of full sweeps (lo->hi->lo), sampled on start
//   hold      in   1        freeze counter, state and sweep tally while high
//   abort     in   1        terminate sequence; return to IDLE
//   count     out  WIDTH    counter value (registered)
//   dir       out  1        0 = counting up, 1 = counting down (registered)
//   busy      out  1        high in UP/DOWN states
//   done      out  1        1-cycle pulse on normal completion
//   cfg_err   out  1        1-cycle pulse when start is rejected
// BEHAVIOUR
//   Reset: state IDLE; count=0, dir=0, busy=0, done=0, cfg_err=0; internal lo_r/hi_r/n_r/tally=0.
//   States: IDLE, UP, DOWN, DONE. All outputs are registered.
//   IDLE: start=1 with lo<hi and n_cycles!=0 -> latch lo_r/hi_r/n_r, count<=lo, dir<=0, tally<=0, ->UP.
//         start=1 with lo>=hi or n_cycles==0 -> cfg_err=1 next cycle, stay IDLE, count unchanged.
//   UP (hold=0): count!=hi_r -> count+1; count==hi_r -> count<=hi_r-1, dir<=1, ->DOWN.
//   DOWN (hold=0): count!=lo_r -> count-1;
//         count==lo_r -> tally+1; if tally+1==n_r -> ->DONE (count stays lo_r)
//         else count<=lo_r+1, dir<=0, ->UP.
//   DONE: done=1 for exactly one cycle, dir<=0, ->IDLE; count holds lo_r.
//   Timing: the accepted start is sampled at edge 0, giving count=lo at cycle 1.
//         Each sweep takes 2*(hi_r-lo_r) cycles. Peak and valley values appear exactly once per sweep.
//         Valleys between consecutive sweeps are not duplicated.
//   Arithmetic: unsigned, WIDTH bits. With lo<hi enforced, the count never wraps (0..2^WIDTH-1 safe).
//   hold: in UP/DOWN, freezes count, dir, state and tally. Ignored in IDLE/DONE.
//   abort: in UP/DOWN/DONE -> IDLE next cycle. No done pulse; count and dir hold their current values.
//         abort has priority over hold and over completion in the same cycle. Ignored in IDLE.
//   start while busy or in DONE: ignored, with no cfg_err.
//   start and abort together in IDLE: start wins.
//   rst mid-sequence: immediate return to reset values on next edge; no done pulse.
//   done and cfg_err are never high in the same cycle. busy=0 whenever done=1.
// TESTING
//   lo=2,hi=5,n=1, start pulse -> count 2,3,4,5,4,3,2 on cycles 1-7, dir=1 on 4..2 descent, done=1 cycle 8, busy=0 cycle 8.
//   lo=0,hi=15,n=2 -> 0..15..0..15..0 with no wrap, single 0 between sweeps, done after 60 active cycles.
//   lo=3,hi=6,n=2, hold high 3 cycles at count=6 -> count/dir/tally frozen, sequence completes 3 cycles late.
//   lo=4,hi=4 start -> cfg_err=1 one cycle, busy stays 0. n_cycles=0 -> same response.
//   Mid-sweep abort at count=5 -> IDLE next cycle, count=5, no done. New start while busy -> no effect.
//   rst during DOWN at count=3 -> next cycle count=0, dir=0, busy=0, done=0, state IDLE.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: walks an up/down counter lo->hi->lo for a programmed
// number of sweeps, with start/busy/done handshake, hold and abort.
module updown_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int NCYC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [NCYC_W-1:0] n_cycles,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0]  W_ONE = 1;
    localparam logic [NCYC_W-1:0] N_ONE = 1;

    logic [1:0]        state;
    logic [WIDTH-1:0]  lo_r;
    logic [WIDTH-1:0]  hi_r;
    logic [NCYC_W-1:0] n_r;
    logic [NCYC_W-1:0] tally;
    logic [NCYC_W-1:0] tally_inc;

    assign tally_inc = tally + N_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            count   <= '0;
            dir     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            lo_r    <= '0;
            hi_r    <= '0;
            n_r     <= '0;
            tally   <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (lo < hi && n_cycles != '0) begin
                            lo_r  <= lo;
                            hi_r  <= hi;
                            n_r   <= n_cycles;
                            count <= lo;
                            dir   <= 1'b0;
                            tally <= '0;
                            busy  <= 1'b1;
                            state <= S_UP;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (!hold) begin
                        if (count != hi_r) begin
                            count <= count + W_ONE;
                        end else begin
                            // Peak is shown once; the first descent value follows immediately.
                            count <= hi_r - W_ONE;
                            dir   <= 1'b1;
                            state <= S_DOWN;
                        end
                    end
                end
                S_DOWN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (!hold) begin
                        if (count != lo_r) begin
                            count <= count - W_ONE;
                        end else begin
                            tally <= tally_inc;
                            if (tally_inc == n_r) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                // Skip lo on the way back up so valleys are not duplicated.
                                count <= lo_r + W_ONE;
                                dir   <= 1'b0;
                                state <= S_UP;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!abort) begin
                        dir <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: a trajectory-list reference model predicts
// every cycle's outputs; a monitor compares them one cycle-sample at a time.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, hold, abort;
    logic [3:0] lo, hi, n_cycles;
    logic [3:0] count;
    logic       dir, busy, done, cfg_err;

    updown_sweep_ctrl #(.WIDTH(4), .NCYC_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .n_cycles(n_cycles),
        .hold(hold), .abort(abort), .count(count), .dir(dir), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] c;
        logic       d;
        logic       b;
        logic       dn;
        logic       ce;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a whole sequence is the precomputed list of (count,dir) points.
    int m_mode = 0;  // 0 idle, 1 running, 2 done
    int m_count = 0, m_dir = 0, m_busy = 0, m_done = 0, m_cfg = 0;
    int tr_c[$];
    int tr_d[$];
    int idx = 0;

    task automatic build_traj(input int l, input int h, input int n);
        tr_c.delete();
        tr_d.delete();
        for (int k = 0; k < n; k++) begin
            for (int v = (k == 0) ? l : l + 1; v <= h; v++) begin
                tr_c.push_back(v);
                tr_d.push_back(0);
            end
            for (int v = h - 1; v >= l; v--) begin
                tr_c.push_back(v);
                tr_d.push_back(1);
            end
        end
    endtask

    task automatic model_step();
        m_done = 0;
        m_cfg  = 0;
        if (rst) begin
            m_mode = 0; m_count = 0; m_dir = 0; m_busy = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                if (lo < hi && n_cycles != 0) begin
                    build_traj(int'(lo), int'(hi), int'(n_cycles));
                    idx = 0;
                    m_count = tr_c[0]; m_dir = tr_d[0]; m_busy = 1; m_mode = 1;
                end else begin
                    m_cfg = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0; m_busy = 0;
            end else if (!hold) begin
                if (idx == tr_c.size() - 1) begin
                    m_mode = 2; m_busy = 0; m_done = 1;
                end else begin
                    idx++;
                    m_count = tr_c[idx]; m_dir = tr_d[idx];
                end
            end
        end else begin
            if (!abort) m_dir = 0;
            m_mode = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.c  = 4'(m_count);
        e.d  = 1'(m_dir);
        e.b  = 1'(m_busy);
        e.dn = 1'(m_done);
        e.ce = 1'(m_cfg);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", int'(count), int'(e.c));
                chk("dir", int'(dir), int'(e.d));
                chk("busy", int'(busy), int'(e.b));
                chk("done", int'(done), int'(e.dn));
                chk("cfg_err", int'(cfg_err), int'(e.ce));
                if (done && (busy || cfg_err)) chk("done_exclusive", 1, 0);
            end
        end
    end

    task automatic go(input int l, input int h, input int n);
        lo = 4'(l); hi = 4'(h); n_cycles = 4'(n); start = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model reaches a given running point; an expired budget is a failure.
    task automatic run_until(input int c, input int d, input string nm);
        int k;
        k = 0;
        while (!(m_mode == 1 && m_count == c && (d < 0 || m_dir == d)) && k < 80) begin
            step();
            k++;
        end
        if (k >= 80) chk({nm, "_timeout"}, 1, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; n_cycles = '0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        idle(1);

        go(2, 5, 1);    idle(10);
        go(0, 15, 2);   idle(66);

        go(3, 6, 2);
        run_until(6, -1, "hold_peak");
        hold = 1'b1; idle(3); hold = 1'b0;
        idle(20);

        go(4, 4, 1);    idle(2);
        go(5, 7, 0);    idle(2);

        go(1, 9, 3);
        run_until(4, 0, "busy_start");
        lo = 4'd0; hi = 4'd2; n_cycles = 4'd1; start = 1'b1; step();
        run_until(5, -1, "abort_pt");
        abort = 1'b1; step(); abort = 1'b0;
        idle(3);

        go(1, 6, 2);
        run_until(3, 1, "rst_pt");
        rst = 1'b1; step(); rst = 1'b0;
        idle(3);

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 9) == 0);
            lo = 4'($urandom_range(0, 15));
            hi = ($urandom_range(0, 4) == 0) ? lo : 4'($urandom_range(int'(lo), 15));
            n_cycles = 4'($urandom_range(0, 3));
            hold  = ($urandom_range(0, 6) == 0);
            abort = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
        idle(2);

        @(posedge clk);
        #2;
        if (q.size() != 0) chk("queue_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
